reg_xfer_seq: RTL

//  Sequencer/arbiter for a bank of 12-bit latch registers on one shared internal bus.

---
 rtl/reg_xfer_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/reg_xfer_seq.sv
// reg_xfer_seq: round-robin sequencer for register-to-register transfers and
// clears on a shared internal bus. It drives one-hot output-enable, latch and
// clear strobes plus the common hold line, and every output is registered.
// After RELEASE the sequencer spends one turnaround cycle in IDLE without
// arbitrating. This gives requesters a cycle to act on done/gnt before a level
// request is treated as new, and sets the 5-cycle copy / 4-cycle clear issue
// interval.
module reg_xfer_seq #(
  parameter int NREQ = 4,
  parameter int NREG = 8,
  parameter int REGW = 3
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*REGW-1:0] req_src,
  input  logic [NREQ*REGW-1:0] req_dst,
  input  logic [NREQ-1:0]      req_clr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [NREG-1:0]      oe_bus,
  output logic                 hold,
  output logic [NREG-1:0]      latch,
  output logic [NREG-1:0]      clear
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_ZERO    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // Register index to one-hot strobe; out-of-range indices give no strobe.
  function automatic logic [NREG-1:0] reg_dec(input logic [REGW-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (int'(idx) == i) begin
        v[i] = 1'b1;
      end else begin
        v[i] = v[i];
      end
    end
    return v;
  endfunction

  // Requester number to one-hot vector.
  function automatic logic [NREQ-1:0] req_dec(input logic [RRW-1:0] w);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(w) == i) begin
        v[i] = 1'b1;
      end else begin
        v[i] = v[i];
      end
    end
    return v;
  endfunction

  state_t          state_q, state_d;
  logic [RRW-1:0]  rr_q, rr_d;
  logic [RRW-1:0]  win_q, win_d;
  logic [REGW-1:0] src_q, src_d;
  logic [REGW-1:0] dst_q, dst_d;
  logic            settle_q, settle_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [NREG-1:0] oe_q, oe_d;
  logic            hold_q, hold_d;
  logic [NREG-1:0] latch_q, latch_d;
  logic [NREG-1:0] clear_q, clear_d;

  logic            found_s;
  logic [RRW-1:0]  win_s;
  logic [RRW-1:0]  cand_s;
  logic [REGW-1:0] wsrc_s;
  logic [REGW-1:0] wdst_s;
  logic            wclr_s;

  // Round-robin pick starting at rr_q, plus the winner's request fields.
  always_comb begin
    found_s = 1'b0;
    win_s   = rr_q;
    cand_s  = rr_q;
    wsrc_s  = '0;
    wdst_s  = '0;
    wclr_s  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = RRW'((int'(rr_q) + k) % NREQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        win_s   = win_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (int'(win_s) == i) begin
        wsrc_s = req_src[i*REGW +: REGW];
        wdst_s = req_dst[i*REGW +: REGW];
        wclr_s = req_clr[i];
      end else begin
        wsrc_s = wsrc_s;
      end
    end
  end

  // Next state, captured operation and next registered output values.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    win_d    = win_q;
    src_d    = src_q;
    dst_d    = dst_q;
    settle_d = 1'b0;
    gnt_d    = '0;
    done_d   = '0;
    oe_d     = '0;
    hold_d   = 1'b1;
    latch_d  = '0;
    clear_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (!settle_q && found_s) begin
          win_d = win_s;
          rr_d  = RRW'((int'(win_s) + 1) % NREQ);
          src_d = wsrc_s;
          dst_d = wdst_s;
          gnt_d = req_dec(win_s);
          if (wclr_s) begin
            state_d = S_ZERO;
            clear_d = reg_dec(wdst_s);
          end else begin
            state_d = S_DRIVE;
            oe_d    = reg_dec(wsrc_s);
            hold_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        state_d = S_CAPTURE;
        oe_d    = reg_dec(src_q);
        latch_d = reg_dec(dst_q);
        hold_d  = 1'b0;
      end
      S_CAPTURE: begin
        state_d = S_RELEASE;
        done_d  = req_dec(win_q);
      end
      S_ZERO: begin
        state_d = S_RELEASE;
        done_d  = req_dec(win_q);
      end
      S_RELEASE: begin
        state_d  = S_IDLE;
        settle_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      win_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      settle_q <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      oe_q     <= '0;
      hold_q   <= 1'b1;
      latch_q  <= '0;
      clear_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      settle_q <= settle_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      oe_q     <= oe_d;
      hold_q   <= hold_d;
      latch_q  <= latch_d;
      clear_q  <= clear_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign oe_bus = oe_q;
  assign hold   = hold_q;
  assign latch  = latch_q;
  assign clear  = clear_q;

endmodule
